// File: rtl/johnson_ring_counter_param_if.sv
// Control and status bundle for johnson_ring_counter_param.
//   master: drives en, dir, mode, load, load_val; observes q, idx, tc, err
//   slave : the counter itself (inverse directions)
interface johnson_ring_counter_param_if #(
  parameter int unsigned WIDTH = 4
);
  localparam int unsigned IW = $clog2(2 * WIDTH);

  logic             en;
  logic             dir;
  logic             mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic [IW-1:0]    idx;
  logic             tc;
  logic             err;

  modport master (
    output en, dir, mode, load, load_val,
    input  q, idx, tc, err
  );

  modport slave (
    input  en, dir, mode, load, load_val,
    output q, idx, tc, err
  );
endinterface

// File: rtl/johnson_ring_counter_param.sv
// Parametrised Johnson / ring shift counter with up/down stepping, checked parallel
// load, decoded position index, terminal count and illegal-state self-correction.
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset (q to home, err cleared)
//   bus.en   : advance one step
//   bus.dir  : 0 = up (toward MSB), 1 = down (toward LSB)
//   bus.mode : 0 = Johnson (period 2*WIDTH), 1 = ring (period WIDTH)
//   bus.load / bus.load_val : parallel load; illegal values are rejected to home
//   bus.q    : registered state
//   bus.idx  : position of q in the up sequence (0 when q is illegal)
//   bus.tc   : next enabled step wraps the sequence
//   bus.err  : one-cycle pulse after a correction or a rejected load
module johnson_ring_counter_param #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  johnson_ring_counter_param_if.slave        bus
);
  localparam int unsigned IW = $clog2(2 * WIDTH);

  logic [WIDTH-1:0] q_q, q_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] home;
  logic [WIDTH-1:0] step;
  logic             legal_q, legal_ld;
  logic [IW-1:0]    ones;
  logic [IW-1:0]    ring_pos;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    last;

  // Johnson states are 0^a1^b (v+1 is a power of two or zero) or its complement;
  // ring states are a single set bit.
  function automatic logic is_legal(input logic [WIDTH-1:0] v, input logic ring);
    logic [WIDTH-1:0] nv;
    nv = ~v;
    if (ring) begin
      return (v != '0) && ((v & (v - WIDTH'(1))) == '0);
    end
    return ((v & (v + WIDTH'(1))) == '0) || ((nv & (nv + WIDTH'(1))) == '0);
  endfunction

  always_comb begin
    home     = bus.mode ? WIDTH'(1) : '0;
    legal_q  = is_legal(q_q, bus.mode);
    legal_ld = is_legal(bus.load_val, bus.mode);
  end

  // Ring rotates the end bit back in; Johnson feeds it back inverted.
  always_comb begin
    step = q_q;
    if (bus.dir) begin
      step = {(bus.mode ? q_q[0] : ~q_q[0]), q_q[WIDTH-1:1]};
    end else begin
      step = {q_q[WIDTH-2:0], (bus.mode ? q_q[WIDTH-1] : ~q_q[WIDTH-1])};
    end
  end

  always_comb begin
    q_d   = q_q;
    err_d = 1'b0;
    if (bus.load) begin
      if (legal_ld) begin
        q_d = bus.load_val;
      end else begin
        q_d   = home;
        err_d = 1'b1;
      end
    end else if (!legal_q) begin
      q_d   = home;
      err_d = 1'b1;
    end else if (bus.en) begin
      q_d = step;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q   <= home;
      err_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      err_q <= err_d;
    end
  end

  // Position decode. In the Johnson falling half (MSB set) the index counts down
  // from 2*WIDTH as ones are shed; the modular subtraction stays within IW bits.
  always_comb begin
    ones     = '0;
    ring_pos = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      ones = ones + IW'(q_q[i]);
      if (q_q[i]) begin
        ring_pos = IW'(i);
      end
    end
    idx = '0;
    if (legal_q) begin
      if (bus.mode) begin
        idx = ring_pos;
      end else if (q_q[WIDTH-1]) begin
        idx = IW'(2 * WIDTH) - ones;
      end else begin
        idx = ones;
      end
    end
    last = bus.mode ? IW'(WIDTH - 1) : IW'(2 * WIDTH - 1);
  end

  assign bus.q   = q_q;
  assign bus.err = err_q;
  assign bus.idx = idx;
  assign bus.tc  = bus.en & legal_q & ~bus.load &
                   (bus.dir ? (idx == '0) : (idx == last));

endmodule

// File: tb/tb_johnson_ring_counter_param.sv
module tb_johnson_ring_counter_param;
  localparam int W = 4;
  localparam int IW = $clog2(2 * W);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  johnson_ring_counter_param_if #(.WIDTH(W)) bus ();

  johnson_ring_counter_param #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference sequences: k-th state of the up sequence for each mode.
  function automatic int period(input logic m);
    return m ? W : 2 * W;
  endfunction

  function automatic logic [W-1:0] seq_val(input logic m, input int k);
    longint unsigned v;
    if (m) v = 64'd1 << k;
    else if (k <= W) v = (64'd1 << k) - 64'd1;
    else v = ((64'd1 << W) - 64'd1) << (k - W);
    return W'(v);
  endfunction

  function automatic int pos_of(input logic [W-1:0] v, input logic m);
    for (int k = 0; k < period(m); k++) begin
      if (seq_val(m, k) == v) return k;
    end
    return -1;
  endfunction

  // Behavioural model
  logic [W-1:0] m_q;
  logic         m_err;
  always @(posedge clk) begin
    if (rst) begin
      m_q   <= seq_val(bus.mode, 0);
      m_err <= 1'b0;
    end else if (bus.load) begin
      if (pos_of(bus.load_val, bus.mode) >= 0) begin
        m_q   <= bus.load_val;
        m_err <= 1'b0;
      end else begin
        m_q   <= seq_val(bus.mode, 0);
        m_err <= 1'b1;
      end
    end else if (pos_of(m_q, bus.mode) < 0) begin
      m_q   <= seq_val(bus.mode, 0);
      m_err <= 1'b1;
    end else if (bus.en) begin
      m_q   <= seq_val(bus.mode, bus.dir ?
                 (pos_of(m_q, bus.mode) + period(bus.mode) - 1) % period(bus.mode) :
                 (pos_of(m_q, bus.mode) + 1) % period(bus.mode));
      m_err <= 1'b0;
    end else begin
      m_err <= 1'b0;
    end
  end

  // Per-cycle compare on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      automatic int p = pos_of(m_q, bus.mode);
      automatic int ei = (p < 0) ? 0 : p;
      automatic logic et = bus.en && (p >= 0) && !bus.load &&
                           (bus.dir ? (ei == 0) : (ei == period(bus.mode) - 1));
      chk("model_q", bus.q, m_q);
      chk("model_err", bus.err, m_err);
      chk("model_idx", bus.idx, ei);
      chk("model_tc", bus.tc, et);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] e1 [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
  logic [3:0] e2 [8] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};
  logic [3:0] e3 [5] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
  int         i3 [5] = '{3, 2, 1, 0, 3};

  initial begin
    logic [3:0] held;
    rst = 1'b1;
    bus.en = 1'b0; bus.dir = 1'b0; bus.mode = 1'b0; bus.load = 1'b0; bus.load_val = '0;
    cyc();
    chk_en = 1'b1;
    chk("rst_q", bus.q, 4'b0000);
    chk("rst_err", bus.err, 1'b0);
    chk("rst_idx", bus.idx, 0);
    chk("rst_tc", bus.tc, 1'b0);

    // Johnson up
    rst = 1'b0; bus.en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("jup_q", bus.q, e1[i]);
      chk("jup_idx", bus.idx, (i + 1) % 8);
      chk("jup_tc", bus.tc, (i == 6));
    end

    // Johnson down from reset
    rst = 1'b1; bus.dir = 1'b1;
    cyc();
    chk("jdn_rst_tc", bus.tc, 1'b1);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("jdn_q", bus.q, e2[i]);
      chk("jdn_tc", bus.tc, (i == 7));
    end

    // Ring down from reset
    rst = 1'b1; bus.mode = 1'b1;
    cyc();
    chk("rdn_rst_q", bus.q, 4'b0001);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("rdn_q", bus.q, e3[i]);
      chk("rdn_idx", bus.idx, i3[i]);
      chk("rdn_tc", bus.tc, (i == 3));
    end

    // Bad load then good load
    bus.mode = 1'b0; bus.en = 1'b0; bus.load = 1'b1; bus.load_val = 4'b0110;
    cyc();
    chk("badld_q", bus.q, 4'b0000);
    chk("badld_err", bus.err, 1'b1);
    bus.load_val = 4'b1100;
    cyc();
    chk("goodld_q", bus.q, 4'b1100);
    chk("goodld_err", bus.err, 1'b0);
    chk("goodld_idx", bus.idx, 6);

    // Mode switch from an illegal-in-ring state
    bus.load_val = 4'b0011;
    cyc();
    bus.load = 1'b0; bus.mode = 1'b1; bus.en = 1'b1; bus.dir = 1'b0;
    cyc();
    chk("msw_q", bus.q, 4'b0001);
    chk("msw_err", bus.err, 1'b1);
    cyc();
    chk("msw_step_q", bus.q, 4'b0010);
    chk("msw_step_err", bus.err, 1'b0);

    // Hold, then reset beats load
    bus.en = 1'b0;
    held = bus.q;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("hold_q", bus.q, held);
      chk("hold_tc", bus.tc, 1'b0);
    end
    rst = 1'b1; bus.load = 1'b1; bus.load_val = 4'b1111;
    cyc();
    chk("rstld_q", bus.q, 4'b0001);
    chk("rstld_err", bus.err, 1'b0);
    rst = 1'b0; bus.load = 1'b0;

    // Randomized phase
    for (int n = 0; n < 2000; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      bus.load = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 1) == 1)
        bus.load_val = seq_val(bus.mode, int'($urandom_range(0, period(bus.mode) - 1)));
      else
        bus.load_val = W'($urandom);
      if ($urandom_range(0, 19) == 0) bus.mode = ~bus.mode;
      bus.dir = 1'($urandom_range(0, 1));
      bus.en = ($urandom_range(0, 3) != 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/johnson_ring_counter_param.md
# johnson_ring_counter_param

Parametrised shift-register counter for sequencing and phase generation. It generalises the fixed 4-bit Johnson counter to any width. It adds a run-time ring/Johnson mode, up/down direction, count enable, and a checked synchronous parallel load. It also reports the decoded state index and terminal count, and self-corrects from illegal states.

## Interface
- WIDTH, 4: counter width in bits; legal range 2..32
- IW (localparam), $clog2(2*WIDTH): width of idx
- clk  input  1  rising-edge clock; the block's only clock
- rst  input  1  synchronous, active-high reset
- en  input  1  advance one step this cycle
- dir  input  1  0 = up (shift toward MSB), 1 = down (shift toward LSB)
- mode  input  1  0 = Johnson (period 2*WIDTH), 1 = ring (period WIDTH)
- load  input  1  parallel load request
- load_val  input  WIDTH  value to load
- q  output  WIDTH  registered counter state
- idx  output  IW  decoded position in the up sequence (combinational from q, mode)
- tc  output  1  terminal count; asserted when the next enabled step wraps (combinational)
- err  output  1  registered one-cycle pulse: illegal state corrected or load rejected

## Operation
- Home value H: Johnson mode is all zeros; ring mode is 1 (bit 0 set). H uses the mode sampled in the same cycle.
- Legal states:
  - Johnson: q is 0^a 1^b (ones in the low bits, including all-zero) or 1^a 0^b (ones in the high bits, including all-one), giving 2*WIDTH states.
  - Ring: exactly one bit set.
- Next-state rules, highest priority first, all evaluated at the clk edge:
  1. rst: q <= H, err <= 0.
  2. load: if load_val is legal for the current mode, q <= load_val and err <= 0; otherwise q <= H and err <= 1. en is ignored this cycle.
  3. q is illegal for the current mode (for example after a mode switch): q <= H, err <= 1. This applies regardless of en.
  4. en = 1, step by mode and direction:
     - Johnson up: q <= {q[W-2:0], ~q[W-1]}
     - Johnson down: q <= {~q[0], q[W-1:1]}
     - Ring up: q <= {q[W-2:0], q[W-1]}
     - Ring down: q <= {q[0], q[W-1:1]}
     - err <= 0.
  5. Otherwise q holds and err <= 0.
- idx:
  - Johnson with q[W-1] = 0: idx = popcount(q), range 0..W-1.
  - Johnson with q[W-1] = 1: idx = 2*W - popcount(q), range W..2W-1.
  - Ring: idx = bit position of the set bit.
  - Illegal q: idx = 0.
- tc = en & legal(q) & ~load. It additionally requires one of:
  - dir = 0 and idx = P-1, or
  - dir = 1 and idx = 0,
  - where P = 2*W (Johnson) or W (ring).
- Mode switch: the mode input is not registered. A state that is legal in both modes (for example 0001) continues counting in the new mode. A state illegal in the new mode is corrected per rule 3 on the next edge.
- dir may change on any cycle. The step direction follows dir of the same cycle; no wrap-around penalty.

## Timing
- All q updates take effect on the rising edge following the request: 1-cycle latency for load, step, and correction.
- err is high for exactly the one cycle after the offending edge. Back-to-back bad loads give a continuous err.
- idx and tc settle combinationally from q, mode, dir, en, and load within the same cycle. There is no registered delay.
- Reset values: q = H (0 in Johnson, 1 in ring), err = 0. Hence idx = 0 and tc = en & (dir = 1).
- rst asserted mid-sequence overrides load and en in that cycle.

## Test plan
- WIDTH=4, mode=0, dir=0, en=1 after rst. Required q sequence: 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000. idx counts 0..7; tc is high while q=1000.
- Johnson down from reset. Required q sequence: 1000, 1100, 1110, 1111, 0111, 0011, 0001, 0000. tc is high while q=0000.
- mode=1, dir=1 from reset. Required q sequence: 1000, 0100, 0010, 0001, 1000. idx runs 3, 2, 1, 0, 3; tc is high at q=0001.
- Load 0110 with mode=0 (illegal): q becomes 0000 and err pulses one cycle. Then load 1100: q becomes 1100, err stays 0, and idx reads 6.
- Johnson q=0011, then switch mode to 1: next edge q becomes 0001 and err pulses. Continuing in ring mode, q steps to 0010.
- en=0 holds q for 5 cycles with tc=0. Then assert rst concurrently with load=1 and load_val=1111: q becomes H and err stays 0.
